// File: rtl/cover_toggle_pkg.sv
// Shared constants and FSM state type for the toggle-coverage scheduler.
package cover_toggle_pkg;

   localparam int IDX_W = 64;

   typedef enum logic {
      IDLE,
      OFFER
   } state_t;

endpackage

// File: rtl/cover_rr_pick.sv
// Round-robin find-first-set: returns the first set request bit at or after
// the start position, wrapping past WIDTH-1 back to 0.
module cover_rr_pick #(
   parameter int WIDTH = 130,
   parameter int PW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req,
   input  logic [PW-1:0]    start,
   output logic             found,
   output logic [PW-1:0]    index
);

   logic [PW:0] pos;

   // Scan offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = '0;
      for (int o = WIDTH - 1; o >= 0; o--) begin
         pos = {1'b0, start} + (PW + 1)'(o);
         if (pos >= (PW + 1)'(WIDTH)) begin
            pos = pos - (PW + 1)'(WIDTH);
         end
         if (req[pos[PW-1:0]]) begin
            found = 1'b1;
            index = pos[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/cover_toggle_scheduler.sv
// Collects toggle-point hits and reports each distinct point once, one at a
// time, over a valid/ready stream carrying the global cover index.
module cover_toggle_scheduler
   import cover_toggle_pkg::*;
#(
   parameter int              WIDTH       = 130,
   parameter longint unsigned COVER_INDEX = 0,
   parameter longint unsigned COVER_TOTAL = 8744
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         valid,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IDX_W-1:0]         out_index,
   output logic [$clog2(WIDTH+1)-1:0] hit_count,
   output logic                     all_covered
);

   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int HW = $clog2(WIDTH + 1);

   // The group must lie entirely inside the design's toggle-point space.
   generate
      if (COVER_INDEX + 64'(WIDTH) > COVER_TOTAL) begin : g_range_check
         $error("cover_toggle_scheduler: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
      end
   endgenerate

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] covered;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] pending_next;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    sel;
   logic             found;
   logic [PW-1:0]    pick_index;
   logic             transfer;

   cover_rr_pick #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_pick (
      .req   (pending),
      .start (ptr),
      .found (found),
      .index (pick_index)
   );

   assign out_valid   = (state == OFFER);
   assign all_covered = (hit_count == HW'(WIDTH));

   // Next state, transfer strobe and pending update; clear overrides all.
   always_comb begin
      next_state   = state;
      transfer     = 1'b0;
      pending_next = pending | (valid & ~covered);
      case (state)
         IDLE: begin
            if (found) begin
               next_state = OFFER;
            end
         end
         OFFER: begin
            if (out_ready) begin
               transfer   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (transfer) begin
         pending_next[sel] = 1'b0;
      end
      if (clear) begin
         next_state   = IDLE;
         transfer     = 1'b0;
         pending_next = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Coverage bookkeeping, offer latching and round-robin pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         covered   <= '0;
         pending   <= '0;
         ptr       <= '0;
         sel       <= '0;
         out_index <= '0;
         hit_count <= '0;
      end else if (clear) begin
         covered   <= '0;
         pending   <= '0;
         ptr       <= '0;
         hit_count <= '0;
      end else begin
         pending <= pending_next;
         if (state == IDLE && found) begin
            sel       <= pick_index;
            out_index <= COVER_INDEX + IDX_W'(pick_index);
         end
         if (transfer) begin
            covered[sel] <= 1'b1;
            hit_count    <= hit_count + HW'(1);
            ptr          <= (sel == PW'(WIDTH - 1)) ? '0 : sel + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cover_toggle_scheduler.sv
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a behavioural reference model.
module tb_cover_toggle_scheduler;

   localparam int W    = 130;
   localparam int BASE = 1000;

   logic           clock;
   logic           reset;
   logic [W-1:0]   valid;
   logic           clear;
   logic           out_valid;
   logic           out_ready;
   logic [63:0]    out_index;
   logic [7:0]     hit_count;
   logic           all_covered;

   int checks;
   int errors;

   cover_toggle_scheduler #(
      .WIDTH       (W),
      .COVER_INDEX (BASE),
      .COVER_TOTAL (8744)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .valid       (valid),
      .clear       (clear),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_index   (out_index),
      .hit_count   (hit_count),
      .all_covered (all_covered)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [W-1:0]    valid;
      bit              clear;
      bit              ready;
      bit              exp_valid;
      longint unsigned exp_index;
      int              exp_count;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: plain arrays and integers.
   bit m_cov[W];
   bit m_pend[W];
   bit m_offer;
   int m_sel;
   int m_ptr;
   int m_cnt;
   int seen[W];

   function automatic logic [W-1:0] bits3(input int a, input int b, input int c);
      logic [W-1:0] m;
      m = '0;
      if (a >= 0) m[a] = 1'b1;
      if (b >= 0) m[b] = 1'b1;
      if (c >= 0) m[c] = 1'b1;
      return m;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] v, input bit clr, input bit rdy,
                               input bit ev, input longint unsigned ei, input int ec);
      vec_t t;
      t.valid = v; t.clear = clr; t.ready = rdy;
      t.exp_valid = ev; t.exp_index = ei; t.exp_count = ec;
      return t;
   endfunction

   task automatic check_output(input string name, input longint unsigned act,
                               input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [W-1:0] v, input bit rdy, input bit clr);
      valid     = v;
      out_ready = rdy;
      clear     = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic model_step(input logic [W-1:0] v, input bit rdy, input bit clr);
      bit np[W];
      if (clr) begin
         for (int i = 0; i < W; i++) begin
            m_cov[i] = 0;
            m_pend[i] = 0;
         end
         m_offer = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
         return;
      end
      for (int i = 0; i < W; i++) np[i] = m_pend[i] | (v[i] & !m_cov[i]);
      if (m_offer) begin
         if (rdy) begin
            m_cov[m_sel] = 1;
            np[m_sel] = 0;
            m_cnt++;
            m_ptr = (m_sel + 1) % W;
            m_offer = 0;
         end
      end else begin
         for (int k = 0; k < W; k++) begin
            int j;
            j = (m_ptr + k) % W;
            if (m_pend[j]) begin
               m_offer = 1;
               m_sel = j;
               break;
            end
         end
      end
      for (int i = 0; i < W; i++) m_pend[i] = np[i];
   endtask

   initial begin
      logic [W-1:0] none;
      logic [W-1:0] rv;
      bit           rr;
      int           reports;
      int           bad_seen;

      checks = 0;
      errors = 0;
      none   = '0;
      reset  = 1'b1;
      valid  = '0;
      clear  = 1'b0;
      out_ready = 1'b0;

      // Reset state while reset is held.
      @(posedge clock);
      @(posedge clock);
      #1;
      check_output("reset_out_valid", out_valid, 0);
      check_output("reset_out_index", out_index, 0);
      check_output("reset_hit_count", hit_count, 0);
      check_output("reset_all_covered", all_covered, 0);
      reset = 1'b0;

      // Directed table: single-hit latency, clear, three-way round robin, re-hit.
      vecs.push_back(mk(bits3(5, -1, -1), 0, 1, 0, 0, 0));
      vecs.push_back(mk(none, 0, 1, 1, 1005, 0));
      vecs.push_back(mk(none, 0, 1, 0, 0, 1));
      vecs.push_back(mk(none, 1, 1, 0, 0, 0));
      vecs.push_back(mk(bits3(3, 7, 129), 0, 1, 0, 0, 0));
      vecs.push_back(mk(none, 0, 1, 1, 1003, 0));
      vecs.push_back(mk(none, 0, 1, 0, 0, 1));
      vecs.push_back(mk(none, 0, 1, 1, 1007, 1));
      vecs.push_back(mk(none, 0, 1, 0, 0, 2));
      vecs.push_back(mk(none, 0, 1, 1, 1129, 2));
      vecs.push_back(mk(none, 0, 1, 0, 0, 3));
      vecs.push_back(mk(bits3(3, -1, -1), 0, 1, 0, 0, 3));
      vecs.push_back(mk(none, 0, 1, 0, 0, 3));
      foreach (vecs[n]) begin
         apply_stimulus(vecs[n].valid, vecs[n].ready, vecs[n].clear);
         check_output($sformatf("tab%0d_out_valid", n), out_valid, vecs[n].exp_valid);
         if (vecs[n].exp_valid) check_output($sformatf("tab%0d_out_index", n), out_index, vecs[n].exp_index);
         check_output($sformatf("tab%0d_hit_count", n), hit_count, vecs[n].exp_count);
         check_output($sformatf("tab%0d_all_covered", n), all_covered, 0);
      end

      // Back-pressure: offer of 1010 held for 20 stalled cycles, bit 20 waits.
      apply_stimulus(none, 0, 1);
      apply_stimulus(bits3(10, -1, -1), 0, 0);
      for (int c = 0; c < 20; c++) begin
         apply_stimulus((c == 3) ? bits3(20, -1, -1) : none, 0, 0);
         check_output($sformatf("stall%0d_out_valid", c), out_valid, 1);
         check_output($sformatf("stall%0d_out_index", c), out_index, 1010);
      end
      apply_stimulus(none, 1, 0);
      check_output("stall_xfer_valid", out_valid, 0);
      check_output("stall_xfer_count", hit_count, 1);
      apply_stimulus(none, 1, 0);
      check_output("stall_next_valid", out_valid, 1);
      check_output("stall_next_index", out_index, 1020);
      apply_stimulus(none, 1, 0);
      check_output("stall_next_count", hit_count, 2);

      // Clear during an offer with out_ready high withdraws it.
      apply_stimulus(none, 0, 1);
      apply_stimulus(bits3(40, -1, -1), 0, 0);
      apply_stimulus(none, 0, 0);
      check_output("clr_offer_index", out_index, 1040);
      apply_stimulus(none, 1, 1);
      check_output("clr_out_valid", out_valid, 0);
      check_output("clr_hit_count", hit_count, 0);
      apply_stimulus(none, 1, 0);
      apply_stimulus(none, 1, 0);
      check_output("clr_stays_idle", out_valid, 0);
      apply_stimulus(bits3(40, -1, -1), 1, 0);
      apply_stimulus(none, 1, 0);
      check_output("clr_rehit_valid", out_valid, 1);
      check_output("clr_rehit_index", out_index, 1040);
      apply_stimulus(none, 1, 0);
      check_output("clr_rehit_count", hit_count, 1);

      // Asynchronous reset in the middle of an offer.
      apply_stimulus(bits3(50, -1, -1), 0, 0);
      apply_stimulus(none, 0, 0);
      check_output("rst_pre_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      check_output("rst_async_valid", out_valid, 0);
      check_output("rst_async_count", hit_count, 0);
      check_output("rst_async_index", out_index, 0);
      #1;
      reset = 1'b0;
      apply_stimulus(bits3(0, -1, -1), 1, 0);
      apply_stimulus(none, 1, 0);
      check_output("rst_after_valid", out_valid, 1);
      check_output("rst_after_index", out_index, 1000);

      // Randomized run against the reference model.
      apply_stimulus(none, 0, 1);
      model_step(none, 0, 1);
      for (int i = 0; i < W; i++) seen[i] = 0;
      reports = 0;
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < W; i++) rv[i] = ($urandom_range(0, 15) == 0);
         rr = ($urandom_range(0, 3) != 0);
         valid = rv;
         out_ready = rr;
         clear = 1'b0;
         if (out_valid && rr) begin
            reports++;
            if (out_index >= 64'(BASE) && out_index < 64'(BASE + W))
               seen[int'(out_index) - BASE]++;
         end
         @(posedge clock);
         model_step(rv, rr, 0);
         #1;
         check_output($sformatf("rnd%0d_out_valid", c), out_valid, m_offer);
         if (m_offer) check_output($sformatf("rnd%0d_out_index", c), out_index, BASE + m_sel);
         check_output($sformatf("rnd%0d_hit_count", c), hit_count, m_cnt);
         check_output($sformatf("rnd%0d_all_covered", c), all_covered, (m_cnt == W));
      end
      bad_seen = 0;
      for (int i = 0; i < W; i++) if (seen[i] != 1) bad_seen++;
      check_output("rnd_reports", reports, W);
      check_output("rnd_unique_indices", bad_seen, 0);
      check_output("rnd_all_covered", all_covered, 1);
      check_output("rnd_hit_count", hit_count, W);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cover_toggle_scheduler.md
COVER_TOGGLE_SCHEDULER -- requirements
Module: cover_toggle_scheduler

Interface
REQ-001 Parameter WIDTH, default 130: number of toggle points in this group.
REQ-002 Parameter COVER_INDEX, default 0: global index of bit 0 of this group.
REQ-003 Parameter COVER_TOTAL, default 8744: total toggle points in the design; used only by the elaboration check in REQ-025.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port valid, input, WIDTH: per-point toggle-hit strobes, sampled every clock.
REQ-007 Port clear, input, 1: synchronous request to forget all coverage state.
REQ-008 Port out_valid, output, 1: a report is offered on out_index.
REQ-009 Port out_ready, input, 1: the sink accepts the offered report.
REQ-010 Port out_index, output, 64: global cover index of the offered report.
REQ-011 Port hit_count, output, $clog2(WIDTH+1): number of distinct points reported since reset or clear.
REQ-012 Port all_covered, output, 1: high when hit_count equals WIDTH.

Function
REQ-013 Registers: covered[WIDTH] marks points already reported; pending[WIDTH] marks hits awaiting report; ptr is the round-robin start position, range 0..WIDTH-1.
REQ-014 Capture: each cycle, for every i with valid[i]=1 and covered[i]=0, pending[i] is set 1 at the next edge.
- A hit on a covered point is ignored.
- A repeated hit on a pending point leaves one pending entry.
REQ-015 State machine has two states, IDLE and OFFER; reset state is IDLE.
REQ-016 Transition IDLE→OFFER: in IDLE with any pending bit set, the FSM selects the first pending index at or after ptr, wrapping past WIDTH-1 to 0.
- out_index is loaded with COVER_INDEX + selected index.
- out_valid=1 from the next cycle.
REQ-017 Latency: valid[i] high in cycle N, with i the only pending point and the FSM in IDLE, gives out_valid=1 with the corresponding index in cycle N+2.
REQ-018 Handshake: in OFFER, out_valid and out_index hold stable until a cycle with out_ready=1 (except for clear, REQ-021). Transfer occurs in that cycle.
REQ-019 On transfer (k = the selected index), all of the following happen at the next edge, and the FSM returns to IDLE:
- covered[k]=1 and pending[k]=0.
- hit_count increments by 1.
- ptr becomes k+1, or 0 when k=WIDTH-1.
REQ-020 Throughput is at most one report per 2 cycles. Each point is reported at most once between clears.
REQ-021 Clear has priority over every other update. When clear=1, the next edge applies all of:
- covered=0 and pending=0.
- hit_count=0 and ptr=0.
- FSM goes to IDLE and out_valid=0; an offered report is withdrawn even if out_ready=1 in the same cycle.
- valid hits in the clear cycle are discarded.
REQ-022 If valid[k]=1 in the transfer cycle of point k, pending[k] ends at 0.
REQ-023 all_covered is combinational from hit_count. hit_count never exceeds WIDTH.
REQ-024 out_index arithmetic is unsigned 64-bit; COVER_INDEX + WIDTH - 1 fits without overflow.
REQ-025 Elaboration fails if COVER_INDEX + WIDTH > COVER_TOTAL.

Reset
REQ-026 While reset=1, with immediate effect, independent of clock:
- covered=0, pending=0, ptr=0, FSM=IDLE.
- out_valid=0, out_index=0, hit_count=0, all_covered=0.
REQ-027 Reset asserted mid-OFFER drops out_valid immediately; the report is not counted.
REQ-028 No capture occurs in cycles where reset is high.

Structure
REQ-029 Package cover_toggle_pkg holds the following; nothing block-specific goes in the package:
- constant IDX_W=64.
- the FSM state typedef {IDLE, OFFER}.
REQ-030 Sub-module cover_rr_pick selects the index: combinational round-robin find-first-set over a WIDTH-bit vector with a start pointer; outputs found and index.
REQ-031 All other logic is in cover_toggle_scheduler, clocked only by clock.

Verification
REQ-032 WIDTH=130, COVER_INDEX=1000, out_ready=1; valid[5] pulsed in cycle 10 → out_valid=1, out_index=1005 in cycle 12; hit_count=1 after the transfer.
REQ-033 valid[3], valid[7] and valid[129] pulsed together, ptr=0, out_ready=1 → reports in the order 1003, 1007, 1129, spaced 2 cycles apart; hit_count=3.
REQ-034 out_ready=0 for 20 cycles during an offer of 1010 → out_index stays 1010 throughout; a new hit on bit 20 meanwhile is reported only after the 1010 transfer.
REQ-035 All 130 bits hit repeatedly over 1000 cycles, with random out_ready → exactly 130 reports, each index 1000..1129 appearing exactly once; all_covered=1.
REQ-036 clear asserted in an OFFER cycle with out_ready=1 → no transfer; out_valid=0, hit_count=0; a later hit on that bit is reported again.
REQ-037 reset asserted mid-OFFER → out_valid=0 with no clock edge; after release, a hit on bit 0 → out_index=1000 two cycles later.
